// File: rtl/fixed_point_unit_arbiter_pkg.sv
// ============================================================================
// fixed_point_unit_arbiter_pkg: opcodes and arbiter state encoding shared by
// the fixed-point unit arbiter. Rev 1.0
// ============================================================================
`default_nettype none

package fixed_point_unit_arbiter_pkg;

  localparam logic [1:0] FPU_ADD  = 2'd0;
  localparam logic [1:0] FPU_SUB  = 2'd1;
  localparam logic [1:0] FPU_MUL  = 2'd2;
  localparam logic [1:0] FPU_SQRT = 2'd3;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/fixed_point_unit_arbiter_rr_arbiter_2.sv
// ============================================================================
// rr_arbiter_2: combinational two-way round-robin grant (one-hot).
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_arbiter_2 (
  input  logic [1:0] valid,
  input  logic       rr_ptr,
  output logic [1:0] grant
);

  always_comb begin
    grant = valid;
    if (&valid) begin
      grant = rr_ptr ? 2'b10 : 2'b01;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fixed_point_unit_arbiter.sv
// ============================================================================
// fixed_point_unit_arbiter: shares one fixed-point unit between two requesters
// with round-robin grant, operand hold, one-cycle response and watchdog abort.
// Rev 1.0
// ============================================================================
`default_nettype none

module fixed_point_unit_arbiter
  import fixed_point_unit_arbiter_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int FBITS          = 10,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*WIDTH-1:0] req_operand_1,
  input  logic [2*WIDTH-1:0] req_operand_2,
  input  logic [3:0]         req_operation,
  output logic [1:0]         resp_valid,
  output logic [WIDTH-1:0]   resp_result,
  output logic               resp_error,
  output logic [WIDTH-1:0]   fpu_operand_1,
  output logic [WIDTH-1:0]   fpu_operand_2,
  output logic [1:0]         fpu_operation,
  output logic               fpu_enable,
  input  logic [WIDTH-1:0]   fpu_result,
  input  logic               fpu_ready,
  output logic               busy
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  // FBITS only describes the unit's format; reject nonsensical combinations early.
  if (FBITS >= WIDTH || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("fixed_point_unit_arbiter: illegal FBITS/TIMEOUT_CYCLES");
  end

  arb_state_t       state, next_state;
  logic             rr_ptr;
  logic             owner;
  logic [CNT_W-1:0] counter;
  logic [1:0]       grant;
  logic             accept;
  logic             gsel;
  logic             timeout;

  rr_arbiter_2 u_rr (
    .valid  (req_valid),
    .rr_ptr (rr_ptr),
    .grant  (grant)
  );

  assign gsel    = grant[1];
  assign accept  = |(req_valid & req_ready);
  assign timeout = (counter == CNT_LAST);
  assign busy    = (state != ARB_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ARB_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    req_ready  = 2'b00;
    resp_valid = 2'b00;
    unique case (state)
      ARB_IDLE: begin
        req_ready = grant;
        if (accept) next_state = ARB_BUSY;
      end
      ARB_BUSY: begin
        if (fpu_ready || timeout) next_state = ARB_RESP;
      end
      ARB_RESP: begin
        resp_valid = owner ? 2'b10 : 2'b01;
        next_state = ARB_IDLE;
      end
      default: next_state = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr        <= 1'b0;
      owner         <= 1'b0;
      counter       <= '0;
      fpu_operand_1 <= '0;
      fpu_operand_2 <= '0;
      fpu_operation <= 2'b00;
      fpu_enable    <= 1'b0;
      resp_result   <= '0;
      resp_error    <= 1'b0;
    end else if (state == ARB_IDLE) begin
      if (accept) begin
        fpu_operand_1 <= gsel ? req_operand_1[2*WIDTH-1:WIDTH] : req_operand_1[WIDTH-1:0];
        fpu_operand_2 <= gsel ? req_operand_2[2*WIDTH-1:WIDTH] : req_operand_2[WIDTH-1:0];
        fpu_operation <= gsel ? req_operation[3:2] : req_operation[1:0];
        owner         <= gsel;
        rr_ptr        <= ~gsel;
        fpu_enable    <= 1'b1;
        counter       <= '0;
      end
    end else if (state == ARB_BUSY) begin
      counter <= counter + 1'b1;
      // A result arriving on the final watchdog cycle still wins over the abort.
      if (fpu_ready) begin
        resp_result <= fpu_result;
        resp_error  <= 1'b0;
        fpu_enable  <= 1'b0;
      end else if (timeout) begin
        resp_result <= '0;
        resp_error  <= 1'b1;
        fpu_enable  <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fixed_point_unit_arbiter.sv
// ============================================================================
// tb_fixed_point_unit_arbiter: directed self-checking bench for the arbiter.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fixed_point_unit_arbiter;
  import fixed_point_unit_arbiter_pkg::*;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [2*W-1:0] req_operand_1;
  logic [2*W-1:0] req_operand_2;
  logic [3:0]     req_operation;
  logic [1:0]     resp_valid;
  logic [W-1:0]   resp_result;
  logic           resp_error;
  logic [W-1:0]   fpu_operand_1;
  logic [W-1:0]   fpu_operand_2;
  logic [1:0]     fpu_operation;
  logic           fpu_enable;
  logic [W-1:0]   fpu_result;
  logic           fpu_ready;
  logic           busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fixed_point_unit_arbiter #(
    .WIDTH          (W),
    .FBITS          (10),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_operand_1 (req_operand_1),
    .req_operand_2 (req_operand_2),
    .req_operation (req_operation),
    .resp_valid    (resp_valid),
    .resp_result   (resp_result),
    .resp_error    (resp_error),
    .fpu_operand_1 (fpu_operand_1),
    .fpu_operand_2 (fpu_operand_2),
    .fpu_operation (fpu_operation),
    .fpu_enable    (fpu_enable),
    .fpu_result    (fpu_result),
    .fpu_ready     (fpu_ready),
    .busy          (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_port(input int p, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b);
    req_operand_1[p*W +: W] = a;
    req_operand_2[p*W +: W] = b;
    req_operation[p*2 +: 2] = op;
  endtask

  initial begin : stim
    logic [3:0] exp_g;
    exp_g         = 4'b1010;
    reset         = 1'b0;
    req_valid     = 2'b00;
    req_operand_1 = '0;
    req_operand_2 = '0;
    req_operation = '0;
    fpu_result    = '0;
    fpu_ready     = 1'b0;

    // Reset state
    adv(2);
    check("rst_busy", busy, 0);
    check("rst_ready", req_ready, 0);
    check("rst_enable", fpu_enable, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_error", resp_error, 0);
    check("rst_resp_result", resp_result, 0);
    check("rst_op1", fpu_operand_1, 0);
    check("rst_opc", fpu_operation, 0);
    reset = 1'b1;

    // Contention: both always valid, grants alternate 0,1,0,1
    set_port(0, FPU_ADD, 32'h100, 32'h200);
    set_port(1, FPU_SUB, 32'h300, 32'h050);
    req_valid  = 2'b11;
    fpu_ready  = 1'b1;
    fpu_result = 32'h111;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("cont_ready", req_ready, exp_g[k] ? 2'b10 : 2'b01);
      adv(1);
      check("cont_op1", fpu_operand_1, exp_g[k] ? 32'h300 : 32'h100);
      check("cont_opc", fpu_operation, exp_g[k] ? FPU_SUB : FPU_ADD);
      adv(1);
      check("cont_resp", resp_valid, exp_g[k] ? 2'b10 : 2'b01);
      adv(1);
    end
    req_valid = 2'b00;

    // Single add with same-cycle ready: 3.0 + 1.0 = 4.0 in Q22.10
    set_port(0, FPU_ADD, 32'h0000_0C00, 32'h0000_0400);
    req_valid  = 2'b01;
    fpu_result = 32'h0000_1000;
    #1;
    check("add_ready", req_ready, 2'b01);
    adv(1);
    check("add_busy", busy, 1);
    check("add_enable", fpu_enable, 1);
    check("add_op2", fpu_operand_2, 32'h400);
    check("add_no_ready", req_ready, 0);
    req_operand_1[31:0] = 32'hDEAD;
    req_valid = 2'b00;
    #1;
    check("add_op1_held", fpu_operand_1, 32'hC00);
    adv(1);
    check("add_resp_valid", resp_valid, 2'b01);
    check("add_result", resp_result, 32'h1000);
    check("add_error", resp_error, 0);
    check("add_enable_low", fpu_enable, 0);
    adv(1);
    check("add_idle_resp", resp_valid, 0);
    check("add_idle_busy", busy, 0);

    // Port 1 multiply, unit ready in 5th BUSY cycle: 3.0 * 2.0 = 6.0
    fpu_ready = 1'b0;
    set_port(1, FPU_MUL, 32'h0000_0C00, 32'h0000_0800);
    req_valid = 2'b10;
    #1;
    check("mul_ready", req_ready, 2'b10);
    adv(1);
    req_valid = 2'b00;
    for (int k = 1; k <= 5; k++) begin
      check("mul_enable", fpu_enable, 1);
      check("mul_op1", fpu_operand_1, 32'hC00);
      check("mul_op2", fpu_operand_2, 32'h800);
      check("mul_opc", fpu_operation, FPU_MUL);
      check("mul_no_resp", resp_valid, 0);
      if (k == 5) begin
        fpu_ready  = 1'b1;
        fpu_result = 32'h0000_1800;
      end
      adv(1);
    end
    check("mul_resp_valid", resp_valid, 2'b10);
    check("mul_result", resp_result, 32'h1800);
    check("mul_error", resp_error, 0);
    fpu_ready = 1'b0;
    adv(1);

    // Timeout: 8 BUSY cycles then abort
    set_port(0, FPU_SUB, 32'h5, 32'h3);
    req_valid = 2'b01;
    adv(1);
    req_valid = 2'b00;
    for (int k = 1; k <= 8; k++) begin
      check("to_no_resp", resp_valid, 0);
      check("to_enable", fpu_enable, 1);
      adv(1);
    end
    check("to_resp_valid", resp_valid, 2'b01);
    check("to_error", resp_error, 1);
    check("to_result", resp_result, 0);
    check("to_enable_low", fpu_enable, 0);
    adv(1);
    check("to_idle", busy, 0);

    // Ready on the last watchdog cycle beats the abort
    set_port(1, FPU_ADD, 32'h7, 32'h8);
    req_valid = 2'b10;
    adv(1);
    req_valid = 2'b00;
    for (int k = 1; k <= 8; k++) begin
      check("last_no_resp", resp_valid, 0);
      if (k == 8) begin
        fpu_ready  = 1'b1;
        fpu_result = 32'h2A5;
      end
      adv(1);
    end
    check("last_resp_valid", resp_valid, 2'b10);
    check("last_error", resp_error, 0);
    check("last_result", resp_result, 32'h2A5);
    fpu_ready = 1'b0;
    adv(1);

    // Asynchronous reset in the middle of a SQRT on port 0
    set_port(0, FPU_SQRT, 32'h1000, 32'h0);
    req_valid = 2'b01;
    adv(1);
    req_valid = 2'b00;
    adv(2);
    check("ar_busy_before", busy, 1);
    #2 reset = 1'b0;
    #1;
    check("ar_busy", busy, 0);
    check("ar_enable", fpu_enable, 0);
    check("ar_op1", fpu_operand_1, 0);
    check("ar_opc", fpu_operation, 0);
    check("ar_result", resp_result, 0);
    check("ar_resp_valid", resp_valid, 0);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      adv(1);
      check("ar_no_resp", resp_valid, 0);
      check("ar_idle", busy, 0);
    end
    set_port(0, FPU_MUL, 32'h400, 32'h400);
    set_port(1, FPU_SUB, 32'h9, 32'h1);
    req_valid  = 2'b11;
    fpu_ready  = 1'b1;
    fpu_result = 32'h42;
    #1;
    check("ar_prio", req_ready, 2'b01);
    adv(1);
    req_valid = 2'b00;
    check("ar_new_opc", fpu_operation, FPU_MUL);
    adv(1);
    check("ar_new_resp", resp_valid, 2'b01);
    check("ar_new_result", resp_result, 32'h42);
    fpu_ready = 1'b0;
    adv(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fixed_point_unit_arbiter.md
Name: fixed_point_unit_arbiter

Overview:
- Shares one fixed-point unit (add/sub/mul/sqrt, Q(WIDTH-FBITS).FBITS) between two requesters, e.g. the execute stage (port 0) and a CSR/debug or coprocessor path (port 1).
- Performs round-robin arbitration and latches the winning request's operands and operation.
- Holds the unit's inputs stable until the unit reports ready, then returns the result to the winner with a one-cycle response pulse.
- A watchdog aborts a stuck operation.

Parameters:
- WIDTH, 32, operand/result width
- FBITS, 10, fraction bits (passed through; no arithmetic here)
- TIMEOUT_CYCLES, 64, maximum BUSY cycles before abort (must be >= 2)

Ports:
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  2  per-requester request valid
- req_ready  out  2  per-requester accept; at most one bit high
- req_operand_1  in  2*WIDTH  packed, requester i at [i*WIDTH +: WIDTH]
- req_operand_2  in  2*WIDTH  packed as above
- req_operation  in  4  packed 2-bit opcodes (FPU_ADD/SUB/MUL/SQRT codes)
- resp_valid  out  2  one-cycle result pulse to the owning requester
- resp_result  out  WIDTH  result; valid only while a resp_valid bit is high
- resp_error  out  1  high with resp_valid when the operation timed out
- fpu_operand_1  out  WIDTH  to unit
- fpu_operand_2  out  WIDTH  to unit
- fpu_operation  out  2  to unit
- fpu_enable  out  1  high while the unit is computing for the current owner
- fpu_result  in  WIDTH  from unit
- fpu_ready  in  1  from unit; may be combinational (add/sub)
- busy  out  1  state != IDLE

Behaviour:
- Reset (reset==0, asynchronous) forces:
  - state=IDLE, rr_ptr=0 (requester 0 has priority), owner=0, timeout counter=0.
  - All operand/operation registers 0, fpu_enable=0, resp_valid=0, resp_error=0, resp_result=0.
- Reset mid-operation drops the in-flight request silently; no response is issued.
- States:
  - IDLE:
    - Grant is combinational. Only one valid → grant it. Both valid → grant rr_ptr.
    - req_ready[g]=1 for the granted g only; req_ready=0 in all other states.
    - On acceptance (valid&&ready):
      - Latch operands and operation from g; owner<=g; rr_ptr<=~g.
      - fpu_enable<=1, counter<=0, go to BUSY.
  - BUSY:
    - fpu_* outputs held constant; counter increments each cycle.
    - fpu_ready==1 sampled → latch fpu_result into resp_result, resp_error<=0, fpu_enable<=0, go to RESP.
    - Else if counter==TIMEOUT_CYCLES-1 → resp_result<=0, resp_error<=1, fpu_enable<=0, go to RESP.
    - fpu_ready takes precedence over timeout in the same cycle.
  - RESP:
    - resp_valid[owner]=1 for exactly this one cycle; fpu_enable=0 (drain cycle lets the unit's internal state machines clear).
    - Unconditionally return to IDLE.
- Latency: acceptance at cycle T.
  - Add/sub (ready same cycle): BUSY at T+1, resp_valid at T+2.
  - Unit latency of L BUSY cycles: resp_valid at T+1+L.
- Throughput: a new request can be accepted in the IDLE cycle after RESP. Back-to-back minimum spacing is 3 cycles.
- No response backpressure; requesters must accept resp_valid when issued.
- Requester inputs may change after acceptance without effect.
- A requester whose valid drops before acceptance loses nothing; no state is kept.
- Invalid behaviour: none. All 4 opcodes are legal and passed through unchanged.

Decomposition:
- Shared package/defines (existing defines header): FPU_ADD/SUB/MUL/SQRT opcodes; new ARB_IDLE/ARB_BUSY/ARB_RESP state constants (2-bit).
- Sub-module rr_arbiter_2: combinational 2-way round-robin grant from valid and rr_ptr, producing grant one-hot.
- Pointer and state registers stay in the top module.

Test Plan:
- Single add: port 0 requests op=ADD, 0x00000C00 + 0x00000400, fpu_ready tied same-cycle → resp_valid=2'b01 at T+2, resp_result=0x00001000, resp_error=0.
- Contention: both ports request in the same cycle after reset → port 0 granted first. Port 1 is still valid, so it is granted in the next IDLE cycle. Then both valid again → port 0. Grants alternate 0,1,0,1.
- Multi-cycle mul: port 1 MUL with the unit model asserting ready after 5 BUSY cycles → fpu_* stable all 5 cycles, resp_valid=2'b10 at T+6, resp_result equals model output.
- Timeout: TIMEOUT_CYCLES=8, fpu_ready held 0 → RESP after 8 BUSY cycles, resp_result=0, resp_error=1, fpu_enable low from the RESP cycle.
- Ready on last timeout cycle: fpu_ready=1 when counter==TIMEOUT_CYCLES-1 → resp_error=0, result from unit.
- Async reset mid-BUSY: assert reset for 1 ns between edges during SQRT → outputs immediately at reset values, no resp_valid afterwards, next request accepted normally with port 0 priority.
